ring_fifo: RTL and testbench
============================

Name: ring_fifo

Overview:
- Parametrised circular buffer, successor to the one-hot-pointer ring buffer used for in-order pipeline queues such as issue queues and commit queues.
- Uses binary head/tail pointers, an occupancy counter and a valid/ready handshake on both sides.
- Adds full/empty/almost-full status, a flush, and an allocation index so producers can tag entries.
- Sits between a producer stage and an in-order consumer; one clock domain.

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 8: number of slots; must be a power of two, 2..256.
- AF_LEVEL, 6: o_afull asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AW, $clog2(DEPTH): index width; derived, not overridden.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous clear of all entries.
- i_push  in  1  producer offers i_data.
- i_data  in  WIDTH  write data.
- o_ready  out  1  buffer can accept a push this cycle.
- o_wr_idx  out  AW  slot index the next accepted push will occupy (equals tail).
- i_pop  in  1  consumer takes the head entry.
- o_valid  out  1  head entry present.
- o_data  out  WIDTH  head entry data; zero when o_valid=0.
- o_rd_idx  out  AW  slot index of the head.
- o_count  out  AW+1  occupancy, 0..DEPTH.
- o_full  out  1  count == DEPTH.
- o_afull  out  1  count >= AF_LEVEL.

Behaviour:
- Reset (async assert, sync release): head=0, tail=0, count=0.
  - Outputs under reset: o_valid=0, o_ready=1, o_full=0, o_afull=0, o_data=0, o_wr_idx=0, o_rd_idx=0.
  - Slot storage is not reset.
- Status outputs are derived combinationally from the registers:
  - o_ready = !o_full.
  - o_valid = (count != 0).
  - o_data = mem[head] gated by o_valid.
- Push handshake:
  - push_fire = i_push & o_ready.
  - On the clock edge, mem[tail] <= i_data and tail <= tail+1 modulo DEPTH.
  - An i_push while full is ignored; no state change, no error.
- Pop handshake:
  - pop_fire = i_pop & o_valid.
  - On the clock edge, head <= head+1 modulo DEPTH.
  - An i_pop while empty is ignored.
- Count update: +1 on push only, -1 on pop only, unchanged when both fire or neither fires.
- Simultaneous push and pop when full: o_ready=0, so only the pop fires; count becomes DEPTH-1. A push is not accepted against a same-cycle pop.
- Simultaneous push and pop when empty (without the optional feature): only the push fires; the data appears on o_data the next cycle.
- Latency: a pushed entry is visible on o_data one cycle after push_fire.
- Wrap-around: both pointers wrap from DEPTH-1 to 0 with no gap. Full and empty are distinguished by count only.
- Flush:
  - i_flush has priority over push and pop in the same cycle; push data is discarded.
  - Next cycle: head=0, tail=0, count=0.
  - Outputs in the flush cycle still reflect pre-flush state.
- Reset mid-operation: all pointers and the count clear immediately; in-flight handshakes are lost.

Optional Feature:
- Macro: RING_FIFO_BYPASS_EN.
- Defined: when count==0 and i_push and i_pop are both high (and no i_flush):
  - o_valid=1 and o_data=i_data combinationally in that cycle.
  - The entry passes through: pointers advance together, count stays 0, and no slot content is relied upon.
  - o_ready is unaffected.
- Undefined: o_valid depends only on the registered count; the behaviour is as described above. No bypass mux is present.

Test Plan:
- Reset: assert i_rst for 2 cycles with i_push=1, then release -> o_count=0, o_valid=0, o_ready=1, o_data=0x0 throughout reset; first push accepted in the first cycle after release.
- Fill and drain, with WIDTH=8, DEPTH=4, AF_LEVEL=3:
  - Push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> o_afull=1 after the third push, o_full=1 and o_ready=0 after the fourth.
  - A fifth push of 0x55 is ignored.
  - Pop 4 times -> o_data 0x11, 0x22, 0x33, 0x44 in order, then o_valid=0.
- Wrap-around and index, DEPTH=4: perform 6 push/pop pairs at steady count 1 -> o_wr_idx sequence is 1,2,3,0,1,2; data order is preserved across the 3->0 wrap.
- Full plus simultaneous push/pop: with the buffer full, drive i_push=1 and i_pop=1 -> only the pop fires; o_count goes 4->3 and the pushed value is absent from later pops.
- Flush priority: with count=3, drive i_flush=1, i_push=1, i_pop=1 together -> next cycle o_count=0, o_rd_idx=0, o_wr_idx=0, o_valid=0.
- Bypass, run with and without the macro:
  - Empty buffer, push 0xA5 and pop in the same cycle.
  - With RING_FIFO_BYPASS_EN: o_valid=1 and o_data=0xA5 in that cycle, o_count stays 0.
  - Without it: o_valid=0 in that cycle; next cycle o_data=0xA5 and o_count=1.

Source files
------------

// File: rtl/ring_fifo.sv
// ring_fifo: parametrised circular buffer for in-order pipeline queues.
//
// Binary head/tail pointers with an occupancy counter; full and empty are
// told apart by the counter alone. Valid/ready handshake on both sides,
// synchronous flush, and an allocation index (o_wr_idx) for tagging entries.
//
// Optional build macro: RING_FIFO_BYPASS_EN
//   When defined, an empty buffer with same-cycle push and pop passes i_data
//   straight to o_data and both pointers advance together (count stays 0).
//
// Ports:
//   i_clk     clock, all state changes on the rising edge
//   i_rst     asynchronous active-high reset
//   i_flush   synchronous clear, wins over push and pop
//   i_push    producer offers i_data
//   i_data    write data
//   o_ready   a push is accepted this cycle (not full)
//   o_wr_idx  slot the next accepted push will occupy (tail)
//   i_pop     consumer takes the head entry
//   o_valid   head entry present
//   o_data    head entry data, zero when o_valid is low
//   o_rd_idx  slot index of the head
//   o_count   occupancy 0..DEPTH
//   o_full    count == DEPTH
//   o_afull   count >= AF_LEVEL
module ring_fifo #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic [AW-1:0]    o_wr_idx,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [AW-1:0]    o_rd_idx,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_afull
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             push_fire, pop_fire;

  assign o_full   = (count_q == FULL_CNT);
  assign o_afull  = (count_q >= AF_CNT);
  assign o_ready  = ~o_full;
  assign o_count  = count_q;
  assign o_wr_idx = tail_q;
  assign o_rd_idx = head_q;

`ifdef RING_FIFO_BYPASS_EN
  logic bypass;
  // Pass-through only from an empty buffer; a flush suppresses it.
  assign bypass  = (count_q == '0) & i_push & i_pop & ~i_flush;
  assign o_valid = (count_q != '0) | bypass;
  assign o_data  = (count_q != '0) ? mem_q[head_q] : (bypass ? i_data : '0);
`else
  assign o_valid = (count_q != '0);
  assign o_data  = o_valid ? mem_q[head_q] : '0;
`endif

  assign push_fire = i_push & o_ready;
  assign pop_fire  = i_pop & o_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_fire) tail_d = tail_q + 1'b1;
      if (pop_fire)  head_d = head_q + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Slot storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (push_fire && !i_flush) mem_q[tail_q] <= i_data;
  end

endmodule

// File: tb/tb_ring_fifo.sv
module tb_ring_fifo;

  localparam int W = 8;
  localparam int D = 4;
  localparam int AF = 3;
`ifdef RING_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         i_rst, i_flush, i_push, i_pop;
  logic [W-1:0] i_data;
  logic         o_ready, o_valid, o_full, o_afull;
  logic [1:0]   o_wr_idx, o_rd_idx;
  logic [2:0]   o_count;
  logic [W-1:0] o_data;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of entries plus the slot index of the head.
  logic [W-1:0] mq[$];
  int           mhead = 0;

  ring_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_push(i_push), .i_data(i_data), .o_ready(o_ready), .o_wr_idx(o_wr_idx),
    .i_pop(i_pop), .o_valid(o_valid), .o_data(o_data), .o_rd_idx(o_rd_idx),
    .o_count(o_count), .o_full(o_full), .o_afull(o_afull)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit byp_now();
    return BYP && mq.size() == 0 && i_push && i_pop && !i_flush;
  endfunction

  function automatic logic e_valid();
    return (mq.size() != 0) || byp_now();
  endfunction

  function automatic logic [W-1:0] e_data();
    if (mq.size() != 0) return mq[0];
    if (byp_now()) return i_data;
    return '0;
  endfunction

  function automatic logic [1:0] e_wr();
    return 2'((mhead + mq.size()) % D);
  endfunction

  task automatic drive(input logic push, input logic [W-1:0] d, input logic pop, input logic flush);
    i_push = push; i_data = d; i_pop = pop; i_flush = flush;
    #1;
  endtask

  // Advance one clock edge and apply the specified handshake rules to the model.
  task automatic tick();
    logic r, p, o, f, byp;
    logic [W-1:0] d;
    r = i_rst; p = i_push; o = i_pop; f = i_flush; d = i_data; byp = byp_now();
    @(posedge i_clk);
    if (r || f) begin
      mq.delete(); mhead = 0;
    end else if (byp) begin
      mhead = (mhead + 1) % D;
    end else begin
      bit pf, pp;
      pf = p && (mq.size() < D);
      pp = o && (mq.size() > 0);
      if (pp) begin void'(mq.pop_front()); mhead = (mhead + 1) % D; end
      if (pf) mq.push_back(d);
    end
    #1;
  endtask

  task automatic clear();
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_push = 1'b1; i_data = 8'h77; i_pop = 1'b0; i_flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if (o_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", o_count); end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %0b want 1", o_ready); end
      total++; if (o_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %0h want 0", o_data); end
      total++; if ({o_full, o_afull, o_wr_idx, o_rd_idx} !== 6'b0) begin bad++; $display("FAIL rst_misc: got %0h want 0", {o_full, o_afull, o_wr_idx, o_rd_idx}); end
      @(posedge i_clk);
    end
    #1;
    i_rst = 1'b0;
    #1;
    tick();
    total++; if (o_count !== 3'd1) begin bad++; $display("FAIL rst_first_push_count: got %0d want 1", o_count); end
    total++; if (o_data !== 8'h77) begin bad++; $display("FAIL rst_first_push_data: got %0h want 77", o_data); end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear();
    drive(1'b1, 8'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h20, 1'b0, 1'b0); tick();
    drive(1'b1, 8'h30, 1'b0, 1'b0);
    total++; if (o_count !== 3'd2) begin bad++; $display("FAIL midrst_pre: got %0d want 2", o_count); end
    #2 i_rst = 1'b1;
    #1;
    total++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_wr_idx !== 2'd0) begin bad++; $display("FAIL midrst_async: got count=%0d valid=%0b wr=%0d want 0 0 0", o_count, o_valid, o_wr_idx); end
    @(posedge i_clk); #1;
    i_rst = 1'b0; mq.delete(); mhead = 0;
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    total++; if (o_count !== 3'd0) begin bad++; $display("FAIL midrst_after: got %0d want 0", o_count); end
  endtask

  task automatic test_fill_drain();
    logic [W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, vals[k], 1'b0, 1'b0); tick();
      total++; if (o_afull !== (k >= 2)) begin bad++; $display("FAIL fill_afull%0d: got %0b want %0b", k, o_afull, k >= 2); end
      total++; if (o_full !== (k == 3) || o_ready !== (k != 3)) begin bad++; $display("FAIL fill_full%0d: got full=%0b ready=%0b", k, o_full, o_ready); end
    end
    drive(1'b1, 8'h55, 1'b0, 1'b0); tick();
    total++; if (o_count !== 3'd4) begin bad++; $display("FAIL fill_ignored_push: got %0d want 4", o_count); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      total++; if (o_data !== vals[k]) begin bad++; $display("FAIL drain_data%0d: got %0h want %0h", k, o_data, vals[k]); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin bad++; $display("FAIL drain_empty: got valid=%0b count=%0d", o_valid, o_count); end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_wr [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    clear();
    drive(1'b1, 8'h60, 1'b0, 1'b0); tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'(8'h61 + k), 1'b1, 1'b0);
      total++; if (o_wr_idx !== exp_wr[k]) begin bad++; $display("FAIL wrap_wr_idx%0d: got %0d want %0d", k, o_wr_idx, exp_wr[k]); end
      total++; if (o_data !== 8'(8'h60 + k)) begin bad++; $display("FAIL wrap_data%0d: got %0h want %0h", k, o_data, 8'(8'h60 + k)); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (o_count !== 3'd1 || o_data !== 8'h66) begin bad++; $display("FAIL wrap_end: got count=%0d data=%0h want 1 66", o_count, o_data); end
  endtask

  task automatic test_full_pushpop();
    clear();
    for (int k = 0; k < 4; k++) begin drive(1'b1, 8'(8'h81 + k), 1'b0, 1'b0); tick(); end
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL fullpp_ready: got %0b want 0", o_ready); end
    tick();
    total++; if (o_count !== 3'd3) begin bad++; $display("FAIL fullpp_count: got %0d want 3", o_count); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      total++; if (o_data !== 8'(8'h82 + k)) begin bad++; $display("FAIL fullpp_data%0d: got %0h want %0h", k, o_data, 8'(8'h82 + k)); end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL fullpp_no_extra: got valid=%0b data=%0h want 0", o_valid, o_data); end
  endtask

  task automatic test_flush();
    clear();
    for (int k = 0; k < 3; k++) begin drive(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0); tick(); end
    drive(1'b1, 8'hCC, 1'b1, 1'b1);
    total++; if (o_count !== 3'd3 || o_data !== 8'hC0) begin bad++; $display("FAIL flush_pre: got count=%0d data=%0h want 3 c0", o_count, o_data); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    total++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin bad++; $display("FAIL flush_count: got count=%0d valid=%0b want 0 0", o_count, o_valid); end
    total++; if (o_rd_idx !== 2'd0 || o_wr_idx !== 2'd0) begin bad++; $display("FAIL flush_idx: got rd=%0d wr=%0d want 0 0", o_rd_idx, o_wr_idx); end
  endtask

  task automatic test_bypass();
    clear();
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    if (BYP) begin
      total++; if (o_valid !== 1'b1 || o_data !== 8'hA5) begin bad++; $display("FAIL byp_same: got valid=%0b data=%0h want 1 a5", o_valid, o_data); end
    end else begin
      total++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin bad++; $display("FAIL byp_same: got valid=%0b data=%0h want 0 0", o_valid, o_data); end
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    if (BYP) begin
      total++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_wr_idx !== 2'd1) begin bad++; $display("FAIL byp_next: got count=%0d valid=%0b wr=%0d want 0 0 1", o_count, o_valid, o_wr_idx); end
    end else begin
      total++; if (o_count !== 3'd1 || o_data !== 8'hA5) begin bad++; $display("FAIL byp_next: got count=%0d data=%0h want 1 a5", o_count, o_data); end
    end
  endtask

  task automatic test_random();
    clear();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) < 5),
            1'($urandom_range(0, 39) == 0));
      total++; if (o_count !== 3'(mq.size())) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, o_count, mq.size()); end
      total++; if (o_valid !== e_valid()) begin bad++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, o_valid, e_valid()); end
      total++; if (o_data !== e_data()) begin bad++; $display("FAIL rnd_data@%0d: got %0h want %0h", n, o_data, e_data()); end
      total++; if (o_ready !== (mq.size() != D) || o_full !== (mq.size() == D) || o_afull !== (mq.size() >= AF)) begin
        bad++; $display("FAIL rnd_status@%0d: got ready=%0b full=%0b afull=%0b for count %0d", n, o_ready, o_full, o_afull, mq.size());
      end
      total++; if (o_rd_idx !== 2'(mhead) || o_wr_idx !== e_wr()) begin bad++; $display("FAIL rnd_idx@%0d: got rd=%0d wr=%0d want %0d %0d", n, o_rd_idx, o_wr_idx, mhead, e_wr()); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_fill_drain();
    test_wrap();
    test_full_pushpop();
    test_flush();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
